// File: rtl/pio_sm_array.sv
// Purpose: N-channel PIO execution core (JMP/SET subset) sharing one writable instruction memory.
// Latency: one instruction per enabled, non-stalled SM per cycle; results visible after the next rising edge.
// Backpressure: none; sm_en=0 freezes an SM in place, a delay countdown stalls it for D cycles.
//
// Ports:
//   clk, rst            - sole clock, synchronous active-high reset
//   imem_we/waddr/wdata - host write port into the shared instruction memory
//   sm_en, sm_restart   - per-SM run enable and synchronous restart (restart wins)
//   wrap_bottom/top     - per-SM wrap window, SM i at [i*ADDR_W +: ADDR_W]
//   pc, x, y, stalled   - per-SM registered state, same packing
module pio_sm_array #(
   parameter int  NUM_SM     = 4,
   parameter int  IMEM_DEPTH = 32,
   localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              imem_wdata,
   input  logic [ADDR_W-1:0]        imem_waddr,
   input  logic                     imem_we,
   input  logic [NUM_SM-1:0]        sm_en,
   input  logic [NUM_SM-1:0]        sm_restart,
   input  logic [NUM_SM*ADDR_W-1:0] wrap_bottom,
   input  logic [NUM_SM*ADDR_W-1:0] wrap_top,
   output logic [NUM_SM*ADDR_W-1:0] pc,
   output logic [NUM_SM*32-1:0]     x,
   output logic [NUM_SM*32-1:0]     y,
   output logic [NUM_SM-1:0]        stalled
);

   localparam logic [2:0] OP_JMP = 3'b000;
   localparam logic [2:0] OP_SET = 3'b111;

   // Shared instruction memory; every SM reads it combinationally, so a word
   // written at an edge is only seen by fetches in the following cycles.
   logic [15:0] imem [IMEM_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
      end else if (imem_we) begin
         imem[imem_waddr] <= imem_wdata;
      end
   end

   for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
      logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d, npc;
      logic [ADDR_W-1:0] wb, wt, tgt;
      logic [31:0]       x_q, x_d, y_q, y_d;
      logic [4:0]        cnt_q, cnt_d;
      logic [15:0]       insn;
      logic [2:0]        op, cond;
      logic [4:0]        dly, data;
      logic              taken;

      assign wb   = wrap_bottom[g*ADDR_W +: ADDR_W];
      assign wt   = wrap_top[g*ADDR_W +: ADDR_W];
      assign insn = imem[pc_q];
      assign op   = insn[15:13];
      assign dly  = insn[12:8];
      assign cond = insn[7:5];
      assign data = insn[4:0];
      // Address bits above ADDR_W are dropped.
      assign tgt  = data[ADDR_W-1:0];

      // State register.
      always_ff @(posedge clk) begin
         if (rst) begin
            pc_q   <= '0;
            pend_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
         end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
         end
      end

      // Next-state logic. With a non-zero delay the X/Y effects land
      // immediately, but the computed next PC is parked in pend_q and only
      // applied on the last stall cycle, so the PC visibly stays on the
      // delayed instruction for the whole countdown.
      always_comb begin
         pc_d   = pc_q;
         pend_d = pend_q;
         x_d    = x_q;
         y_d    = y_q;
         cnt_d  = cnt_q;
         taken  = 1'b0;
         npc    = pc_q;
         if (sm_restart[g]) begin
            pc_d  = wb;
            x_d   = '0;
            y_d   = '0;
            cnt_d = '0;
         end else if (sm_en[g]) begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) pc_d = pend_q;
            end else begin
               if (op == OP_JMP) begin
                  case (cond)
                     3'b000: taken = 1'b1;
                     3'b001: taken = (x_q == 32'd0);
                     3'b010: begin
                        taken = (x_q != 32'd0);
                        x_d   = x_q - 32'd1;
                     end
                     3'b011: taken = (y_q == 32'd0);
                     3'b100: begin
                        taken = (y_q != 32'd0);
                        y_d   = y_q - 32'd1;
                     end
                     3'b101: taken = (x_q != y_q);
                     default: taken = 1'b0;
                  endcase
               end else if (op == OP_SET) begin
                  case (cond)
                     3'b001:  x_d = {27'd0, data};
                     3'b010:  y_d = {27'd0, data};
                     default: ;
                  endcase
               end
               // A taken jump beats the wrap; otherwise PC rolls over naturally
               // at IMEM_DEPTH-1 because IMEM_DEPTH is a power of two.
               if (taken)          npc = tgt;
               else if (pc_q == wt) npc = wb;
               else                npc = pc_q + ADDR_W'(1);
               if (dly == 5'd0) begin
                  pc_d = npc;
               end else begin
                  cnt_d  = dly;
                  pend_d = npc;
               end
            end
         end
      end

      // Outputs.
      assign pc[g*ADDR_W +: ADDR_W] = pc_q;
      assign x[g*32 +: 32]          = x_q;
      assign y[g*32 +: 32]          = y_q;
      assign stalled[g]             = (cnt_q != 5'd0);
   end

endmodule

// File: tb/tb_pio_sm_array.sv
// Purpose: scoreboard bench for pio_sm_array with directed programs.
// Latency: expectations are tagged with the cycle they must hold in and checked on the falling edge.
// Backpressure: none; stimulus never waits on the DUT.
module tb_pio_sm_array;
   localparam int N  = 4;
   localparam int AW = 5;
   localparam logic [2:0] JMP = 3'b000;
   localparam logic [2:0] NOP = 3'b001;
   localparam logic [2:0] SET = 3'b111;

   logic            clk = 1'b0;
   logic            rst;
   logic [15:0]     imem_wdata;
   logic [AW-1:0]   imem_waddr;
   logic            imem_we;
   logic [N-1:0]    sm_en, sm_restart;
   logic [N*AW-1:0] wrap_bottom, wrap_top, pc;
   logic [N*32-1:0] x, y;
   logic [N-1:0]    stalled;

   pio_sm_array #(.NUM_SM(N), .IMEM_DEPTH(32)) dut (
      .clk(clk), .rst(rst),
      .imem_wdata(imem_wdata), .imem_waddr(imem_waddr), .imem_we(imem_we),
      .sm_en(sm_en), .sm_restart(sm_restart),
      .wrap_bottom(wrap_bottom), .wrap_top(wrap_top),
      .pc(pc), .x(x), .y(y), .stalled(stalled)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          sm;
      logic [4:0]  pc;
      logic [31:0] x;
      logic [31:0] y;
      logic        st;
   } exp_t;

   exp_t  sb[$];
   string nq[$];
   int    compared   = 0;
   int    mismatched = 0;

   int          t1_pc[6] = '{1, 1, 1, 1, 2, 2};
   logic [31:0] t1_x[6]  = '{32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   int          t2_pc[6] = '{5, 6, 4, 5, 6, 4};

   function automatic logic [15:0] ins(input logic [2:0] op, input logic [4:0] d,
                                       input logic [2:0] c, input logic [4:0] a);
      return {op, d, c, a};
   endfunction

   // Queue an expectation for SM sm, dc cycles from now.
   task automatic chk(input int dc, input int sm, input int epc, input logic [31:0] ex,
                      input logic [31:0] ey, input logic est, input string nm);
      exp_t e;
      e.cyc = cyc + dc;
      e.sm  = sm;
      e.pc  = epc[4:0];
      e.x   = ex;
      e.y   = ey;
      e.st  = est;
      sb.push_back(e);
      nq.push_back(nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      imem_waddr = a[AW-1:0];
      imem_wdata = d;
      imem_we    = 1'b1;
      step();
      imem_we    = 1'b0;
   endtask

   task automatic set_win(input int s, input int b, input int t);
      wrap_bottom[s*AW +: AW] = b[AW-1:0];
      wrap_top[s*AW +: AW]    = t[AW-1:0];
   endtask

   // Monitor: pops every expectation that is due and compares it with the DUT.
   exp_t        m_e;
   string       m_nm;
   logic [4:0]  a_pc;
   logic [31:0] a_x, a_y;
   logic        a_st;
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         m_e  = sb.pop_front();
         m_nm = nq.pop_front();
         a_pc = pc[m_e.sm*AW +: AW];
         a_x  = x[m_e.sm*32 +: 32];
         a_y  = y[m_e.sm*32 +: 32];
         a_st = stalled[m_e.sm];
         compared++;
         if (m_e.cyc != cyc || a_pc !== m_e.pc || a_x !== m_e.x || a_y !== m_e.y || a_st !== m_e.st) begin
            mismatched++;
            $display("FAIL %s sm%0d cyc%0d: got pc=%0d x=%h y=%h st=%b, want pc=%0d x=%h y=%h st=%b",
                     m_nm, m_e.sm, cyc, a_pc, a_x, a_y, a_st, m_e.pc, m_e.x, m_e.y, m_e.st);
         end
      end
   end

   initial begin
      rst = 1'b1; imem_we = 1'b0; imem_wdata = '0; imem_waddr = '0;
      sm_en = '0; sm_restart = '0; wrap_bottom = '0; wrap_top = '0;
      for (int s = 0; s < N; s++) set_win(s, 0, 31);
      step(); step();
      rst = 1'b0;
      for (int s = 0; s < N; s++) chk(0, s, 0, 0, 0, 1'b0, "reset");

      // X-- loop: SET X 3; JMP X-- 1; JMP always 2.
      wr(0, ins(SET, 0, 3'b001, 5'd3));
      wr(1, ins(JMP, 0, 3'b010, 5'd1));
      wr(2, ins(JMP, 0, 3'b000, 5'd2));
      chk(0, 0, 0, 0, 0, 1'b0, "t1_start");
      sm_en = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         chk(1, 0, t1_pc[i], t1_x[i], 0, 1'b0, "t1_xdec");
         step();
      end

      // Wrap window 4..6 on SM1.
      sm_en = '0;
      for (int a = 4; a <= 6; a++) wr(a, ins(NOP, 0, 0, 0));
      set_win(1, 4, 6);
      sm_restart = 4'b0010;
      chk(1, 1, 4, 0, 0, 1'b0, "t2_restart");
      step();
      sm_restart = '0;
      sm_en = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         chk(1, 1, t2_pc[i], 0, 0, 1'b0, "t2_wrap");
         step();
      end
      chk(0, 0, 2, 32'hFFFF_FFFF, 0, 1'b0, "t2_sm0_frozen");

      // NOP with delay 3.
      sm_en = '0;
      wr(0, ins(NOP, 5'd3, 0, 0));
      sm_restart = 4'b0001;
      chk(1, 0, 0, 0, 0, 1'b0, "t3_restart");
      step();
      sm_restart = '0;
      sm_en = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         chk(1, 0, 0, 0, 0, 1'b1, "t3_stall");
         step();
      end
      chk(1, 0, 1, 0, 0, 1'b0, "t3_resume");
      step();
      sm_en = '0;

      // JMP X!=Y not taken, then taken.
      set_win(0, 8, 31);
      wr(8,  ins(SET, 0, 3'b010, 5'd5));
      wr(9,  ins(SET, 0, 3'b001, 5'd5));
      wr(10, ins(JMP, 0, 3'b101, 5'd0));
      wr(11, ins(NOP, 0, 0, 0));
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) wr(8, ins(SET, 0, 3'b010, 5'd6));
         sm_restart = 4'b0001;
         chk(1, 0, 8, 0, 0, 1'b0, "t4_restart");
         step();
         sm_restart = '0;
         sm_en = 4'b0001;
         chk(1, 0, 9, 0, 5 + pass, 1'b0, "t4_sety");
         step();
         chk(1, 0, 10, 5, 5 + pass, 1'b0, "t4_setx");
         step();
         chk(1, 0, (pass == 0) ? 11 : 0, 5, 5 + pass, 1'b0, (pass == 0) ? "t4_not_taken" : "t4_taken");
         step();
         sm_en = '0;
      end

      // Write collision at pc=2.
      set_win(0, 2, 3);
      sm_restart = 4'b0001;
      chk(1, 0, 2, 0, 0, 1'b0, "t5_restart");
      step();
      sm_restart = '0;
      sm_en = 4'b0001;
      imem_waddr = 5'd2;
      imem_wdata = ins(SET, 0, 3'b001, 5'd7);
      imem_we = 1'b1;
      chk(1, 0, 2, 0, 0, 1'b0, "t5_old_word");
      step();
      imem_we = 1'b0;
      chk(1, 0, 3, 7, 0, 1'b0, "t5_new_word");
      step();
      sm_en = '0;

      // Four windows, only SM1/SM3 enabled.
      for (int s = 0; s < N; s++) set_win(s, 16 + 2*s, 17 + 2*s);
      for (int a = 16; a < 24; a++) wr(a, ins(SET, 0, 3'b001, a[4:0]));
      sm_restart = 4'b1111;
      sm_en = 4'b1010;
      for (int s = 0; s < N; s++) chk(1, s, 16 + 2*s, 0, 0, 1'b0, "t6_restart");
      step();
      sm_restart = '0;
      for (int j = 0; j < 2; j++) begin
         for (int s = 0; s < N; s++) begin
            if (s % 2 == 1) chk(1, s, 16 + 2*s + ((j == 0) ? 1 : 0), 16 + 2*s + j, 0, 1'b0, "t6_run");
            else            chk(1, s, 16 + 2*s, 0, 0, 1'b0, "t6_hold");
         end
         step();
      end

      // Delay freeze and restart mid-delay on SM3.
      sm_en = '0;
      wr(24, ins(NOP, 5'd5, 0, 0));
      set_win(3, 24, 24);
      sm_restart = 4'b1000;
      chk(1, 3, 24, 0, 0, 1'b0, "t6_restart3");
      step();
      sm_restart = '0;
      sm_en = 4'b1000;
      chk(1, 3, 24, 0, 0, 1'b1, "t6_delay");
      step();
      chk(1, 3, 24, 0, 0, 1'b1, "t6_delay");
      step();
      sm_en = '0;
      chk(1, 3, 24, 0, 0, 1'b1, "t6_frozen_delay");
      step();
      sm_restart = 4'b1000;
      chk(1, 3, 24, 0, 0, 1'b0, "t6_restart_clears");
      step();
      sm_restart = '0;

      // wrap_top beyond program: 31 -> 0.
      wr(31, ins(NOP, 0, 0, 0));
      set_win(2, 31, 30);
      sm_restart = 4'b0100;
      chk(1, 2, 31, 0, 0, 1'b0, "t7_restart");
      step();
      sm_restart = '0;
      sm_en = 4'b0100;
      chk(1, 2, 0, 0, 0, 1'b0, "t7_depth_wrap");
      step();
      sm_en = '0;

      // rst beats sm_restart and imem_we.
      set_win(1, 5, 31);
      rst = 1'b1;
      sm_restart = 4'b0010;
      imem_waddr = 5'd5;
      imem_wdata = 16'hFFFF;
      imem_we = 1'b1;
      chk(1, 1, 0, 0, 0, 1'b0, "t8_rst_vs_restart");
      step();
      rst = 1'b0;
      imem_we = 1'b0;
      chk(1, 1, 5, 0, 0, 1'b0, "t8_restart");
      step();
      sm_restart = '0;
      sm_en = 4'b0010;
      chk(1, 1, 0, 0, 0, 1'b0, "t8_write_blocked");
      step();
      sm_en = '0;

      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pio_sm_array.md
# pio_sm_array

Parametrised cluster of PIO state machines sharing one writable instruction memory. Each state machine has its own program counter with wrap window, 32-bit X/Y scratch registers and delay counter, and executes the JMP and SET instruction subset. The block generalises the separate program counter, instruction register file and FSM into one N-channel execution core. It sits between the host-facing configuration logic and future pin/FIFO units.

## Interface
- NUM_SM, 4, number of state machines (1..8)
- IMEM_DEPTH, 32, instruction memory words (power of two, 2..32)
- ADDR_W, $clog2(IMEM_DEPTH), PC/address width (derived, not overridden)
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_wdata  in  16  instruction word to write
- imem_waddr  in  ADDR_W  write address
- imem_we  in  1  write strobe
- sm_en  in  NUM_SM  per-SM run enable
- sm_restart  in  NUM_SM  per-SM synchronous restart
- wrap_bottom  in  NUM_SM*ADDR_W  per-SM wrap target, SM i at [i*ADDR_W +: ADDR_W]
- wrap_top  in  NUM_SM*ADDR_W  per-SM wrap source, same packing
- pc  out  NUM_SM*ADDR_W  per-SM program counter, registered
- x  out  NUM_SM*32  per-SM X scratch, registered
- y  out  NUM_SM*32  per-SM Y scratch, registered
- stalled  out  NUM_SM  per-SM delay countdown active, registered

## Operation
- Encoding: [15:13] opcode, [12:8] delay, [7:5] cond/dest, [4:0] addr/data.
- Opcode 000 JMP: target = addr[ADDR_W-1:0]. Conditions: 000 always; 001 X==0; 010 X!=0, then X<=X-1 (decrement regardless of outcome); 011 Y==0; 100 Y!=0, then Y<=Y-1; 101 X!=Y; 110, 111 never taken.
- Opcode 111 SET: dest 001 X<=zero-extended data; 010 Y<=zero-extended data; other dest no effect.
- All other opcodes: NOP (PC advance and delay only).
- Fetch: instruction = imem[pc_i], combinational read; every SM has its own read port.
- Next PC when executing: taken jump -> target; else pc==wrap_top -> wrap_bottom; else pc+1 modulo IMEM_DEPTH.
- Delay: executing an instruction with delay D>0 loads counter=D; for D following cycles SM holds PC/X/Y, stalled=1, counter decrements; execution resumes when counter reaches 0.
- sm_en=0: SM frozen (PC, X, Y, delay counter held); no instruction executes.
- sm_restart_i=1: pc<=wrap_bottom_i, X<=0, Y<=0, counter<=0; takes priority over execution and sm_en.
- Memory write: imem[imem_waddr]<=imem_wdata on imem_we; writes are allowed while SMs run.
- SMs are independent; no inter-SM interaction except the shared memory.

## Timing
- Reset: all pc=0, x=0, y=0, stalled=0, counters=0, every imem word 0x0000 (JMP always 0).
- One instruction per enabled, non-stalled SM per cycle; effects visible on outputs after the next rising edge.
- Write-read collision: a word written at edge k is fetched from cycle k+1 onward; an SM fetching that address in the write cycle executes the old word.
- JMP with X-- and X==0: not taken, X wraps to 0xFFFFFFFF.
- Taken jump at pc==wrap_top goes to target; wrap does not apply.
- wrap_top beyond the program: PC increments through all addresses and wraps at IMEM_DEPTH-1 -> 0.
- JMP addr bits above ADDR_W are ignored.
- sm_en deasserted during delay: counter frozen, stalled stays 1.
- rst overrides sm_restart and imem_we in the same cycle.

## Test plan
- Reset, then load 0:SET X 3; 1:JMP X-- 1; 2:JMP always 2; enable SM0 -> pc 0,1,1,1,1,2,2; X 3,2,1,0,0xFFFFFFFF.
- wrap_bottom=4, wrap_top=6, program of NOPs, restart SM1 -> pc 4,5,6,4,5 repeating.
- NOP with delay 3 at addr 0, enable SM0 -> pc stays 0 for 4 cycles with stalled=1 on cycles 2-4, then pc=1.
- SET Y 5 and SET X 5 then JMP X!=Y 0 -> not taken; change to SET Y 6 -> taken, pc=0.
- Overwrite addr 2 while SM0 sits at pc=2 -> old word executes that cycle, new word on the next visit.
- Four SMs on distinct wrap windows with sm_en=4'b1010 -> SM1/SM3 advance, SM0/SM2 pc/x/y unchanged; sm_restart mid-delay clears stalled next cycle.
